// File: rtl/fifo_byte_reader.sv
// Assembles WORD_W bits popped from a 1-bit synchronous FIFO into a word, LSB first.
// Optional even-parity output is built only when FIFO_BYTE_READER_PARITY_EN is defined.
module fifo_byte_reader #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic              fifo_data_out,
  output logic              fifo_rd_en,
  input  logic              flush,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
`ifdef FIFO_BYTE_READER_PARITY_EN
  output logic              word_parity,
`endif
  input  logic              word_ready,
  output logic              busy
);

  localparam int CW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WORD_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_W - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     issue_cnt, cap_cnt;
  logic              pend_q;
  logic [WORD_W-1:0] word_q, word_next;
  logic              capture, last_bit, handshake;

  // A pending bit is captured unless a flush in FILL discards it.
  assign capture   = (state_q == FILL) && pend_q && !flush;
  assign last_bit  = capture && (cap_cnt == CNT_LAST);
  assign handshake = (state_q == HOLD) && word_valid && word_ready;

  always_comb begin
    word_next = word_q;
    for (int i = 0; i < WORD_W; i++) begin
      if (cap_cnt == CW'(i)) word_next[i] = fifo_data_out;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    busy       = 1'b0;
    case (state_q)
      FILL: begin
        fifo_rd_en = !fifo_empty && (issue_cnt < CNT_FULL) && !flush && !rst;
        busy       = (issue_cnt != '0) || (cap_cnt != '0);
        if (last_bit) state_d = HOLD;
      end
      HOLD: begin
        busy = 1'b1;
        if (word_valid && word_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt   <= '0;
      cap_cnt     <= '0;
      pend_q      <= 1'b0;
      word_q      <= '0;
      word_out    <= '0;
      word_valid  <= 1'b0;
`ifdef FIFO_BYTE_READER_PARITY_EN
      word_parity <= 1'b0;
`endif
    end else begin
      pend_q <= fifo_rd_en;
      if ((state_q == FILL) && flush) begin
        issue_cnt <= '0;
        cap_cnt   <= '0;
      end else if (handshake) begin
        issue_cnt  <= '0;
        cap_cnt    <= '0;
        word_valid <= 1'b0;
      end else begin
        if (fifo_rd_en) issue_cnt <= issue_cnt + CW'(1);
        if (capture) begin
          word_q  <= word_next;
          cap_cnt <= cap_cnt + CW'(1);
        end
        if (last_bit) begin
          word_out    <= word_next;
          word_valid  <= 1'b1;
`ifdef FIFO_BYTE_READER_PARITY_EN
          word_parity <= ^word_next;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_byte_reader.sv
// Self-checking bench for fifo_byte_reader: directed scenarios plus randomized traffic
// against a bit-list reference model of the word assembly.
module tb_fifo_byte_reader;

  localparam int W = 8;
  localparam int FD = 8192;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty;
  logic         fifo_data_out;
  logic         fifo_rd_en;
  logic         flush = 1'b0;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         word_ready = 1'b0;
  logic         busy;
  logic         gate_empty = 1'b0;
`ifdef FIFO_BYTE_READER_PARITY_EN
  logic         word_parity;
  logic         last_par;
`endif

  bit fifo_mem [0:FD-1];
  int wr_ptr = 0;
  int rd_ptr = 0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit           pend [$];
  logic         m_valid = 1'b0;
  logic [W-1:0] m_word = '0;
  logic         last_rd, last_valid;
  logic [W-1:0] last_word;

  fifo_byte_reader #(.WORD_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en),
    .flush         (flush),
    .word_out      (word_out),
    .word_valid    (word_valid),
`ifdef FIFO_BYTE_READER_PARITY_EN
    .word_parity   (word_parity),
`endif
    .word_ready    (word_ready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // 1-bit FIFO: registered read data, valid the cycle after a pop.
  assign fifo_empty = (rd_ptr == wr_ptr) || gate_empty;
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_data_out <= fifo_mem[rd_ptr % FD];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input bit b);
    fifo_mem[wr_ptr % FD] = b;
    wr_ptr++;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) push(w[i]);
  endtask

  // One cycle: compare DUT against model, then advance model with this cycle's inputs.
  task automatic step();
    logic exp_rd;
    bit   pb;
    if (rst) begin
      pend.delete();
      m_valid = 1'b0;
      m_word  = '0;
    end
    #1;
    exp_rd = !rst && !m_valid && !fifo_empty && (pend.size() < W) && !flush;
    check("rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
    check("word_valid", {31'd0, word_valid}, {31'd0, m_valid});
    check("word_out", 32'(word_out), 32'(m_word));
    check("busy", {31'd0, busy}, {31'd0, (m_valid || pend.size() > 0)});
`ifdef FIFO_BYTE_READER_PARITY_EN
    check("word_parity", {31'd0, word_parity}, {31'd0, ^m_word});
    last_par = word_parity;
`endif
    last_rd    = fifo_rd_en;
    last_valid = word_valid;
    last_word  = word_out;
    if (!rst) begin
      pb = fifo_mem[rd_ptr % FD];
      if (m_valid) begin
        if (word_ready) m_valid = 1'b0;
      end else if (flush) begin
        pend.delete();
      end else if (pend.size() == W) begin
        for (int i = 0; i < W; i++) m_word[i] = pend[i];
        m_valid = 1'b1;
        pend.delete();
      end
      if (exp_rd) pend.push_back(pb);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_word(input string tag, input logic [W-1:0] exp);
    bit seen = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      step();
      if (last_valid) begin
        check(tag, 32'(last_word), 32'(exp));
        seen = 1;
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int first_pop, valid_cyc, pops, vcount;
    logic [W-1:0] wv, held;

    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // Streaming: 1,0,1,1,0,0,1,0 -> 8'h4D, nine cycles after the first pop.
    push_word(8'h4D);
    word_ready = 1'b1;
    first_pop = -1; valid_cyc = -1; pops = 0; vcount = 0; wv = '0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (last_rd) begin
        pops++;
        if (first_pop < 0) first_pop = cyc - 1;
      end
      if (last_valid) begin
        vcount++;
        if (valid_cyc < 0) begin
          valid_cyc = cyc - 1;
          wv = last_word;
`ifdef FIFO_BYTE_READER_PARITY_EN
          check("t1_parity", {31'd0, last_par}, 32'd0);
`endif
        end
      end
    end
    check("t1_pops", pops, 8);
    check("t1_latency", valid_cyc - first_pop, 9);
    check("t1_valid_cycles", vcount, 1);
    check("t1_word", 32'(wv), 32'h4D);

    // Empty stall after four bits.
    for (int i = 0; i < 4; i++) push(1'b1);
    repeat (4) step();
    for (int n = 0; n < 5; n++) begin
      step();
      check("t2_gap_rd", {31'd0, last_rd}, 32'd0);
    end
    for (int i = 0; i < 4; i++) push(1'b0);
    wait_word("t2_word", 8'h0F);

    // Parity on an odd-weight word.
    push_word(8'h4C);
    wait_word("t6_word", 8'h4C);
`ifdef FIFO_BYTE_READER_PARITY_EN
    check("t6_parity", {31'd0, last_par}, 32'd1);
`endif

    // Backpressure: six cycles held with data waiting, accept on the seventh.
    word_ready = 1'b0;
    push_word(8'h3C);
    push_word(8'h96);
    wait_word("t3_word", 8'h3C);
    held = last_word;
    for (int n = 0; n < 5; n++) begin
      step();
      check("t3_stable", 32'(last_word), 32'(held));
      check("t3_no_pop", {31'd0, last_rd}, 32'd0);
    end
    word_ready = 1'b1;
    step();
    step();
    check("t3_resume", {31'd0, last_rd}, 32'd1);
    wait_word("t3_word2", 8'h96);

    // Flush with the fifth bit still in flight.
    for (int i = 0; i < 5; i++) push(1'b1);
    repeat (5) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("t4_idle", {31'd0, busy}, 32'd0);
    push_word(8'hA5);
    wait_word("t4_word", 8'hA5);

    // Reset after three bits; the leftover bits start a fresh word.
    push_word(8'h07);
    repeat (3) step();
    rst = 1'b1;
    step();
    check("t5_rd", {31'd0, last_rd}, 32'd0);
    check("t5_valid", {31'd0, last_valid}, 32'd0);
    check("t5_word", 32'(last_word), 32'd0);
    rst = 1'b0;
    push(1'b1); push(1'b0); push(1'b1);
    wait_word("t5_next_word", 8'hA0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(2) != 0) push(1'($urandom));
      word_ready = 1'($urandom);
      gate_empty = ($urandom_range(9) == 0);
      flush      = ($urandom_range(39) == 0);
      rst        = ($urandom_range(499) == 0);
      step();
    end
    rst        = 1'b0;
    flush      = 1'b0;
    gate_empty = 1'b0;
    word_ready = 1'b1;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
